// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle for pipe_stage_reg: upstream valid/ready/data and downstream valid/ready/data.
// The stage binds the slave modport; the surrounding producer/consumer binds master.
interface pipe_stage_reg_if #(
    parameter int DATA_W = 101
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with bubble/stall performance counters.
// Optional macro PIPE_STAGE_SKID_EN adds a skid entry behind the head and registers in_ready.
module pipe_stage_reg #(
    parameter int DATA_W     = 101,
    parameter int CNT_W      = 16,
    parameter int CLEAR_DATA = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    pipe_stage_reg_if.slave     bus,
    input  logic                flush,
    input  logic                cnt_clr,
    output logic [CNT_W-1:0]    bubble_cnt,
    output logic [CNT_W-1:0]    stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == CNT_MAX) begin
            r = v;
        end else begin
            r = v + CNT_ONE;
        end
        return r;
    endfunction

    logic              head_valid_q;
    logic              head_valid_d;
    logic [DATA_W-1:0] head_data_q;
    logic [DATA_W-1:0] head_data_d;
    logic              accept_s;
    logic              drain_s;
    logic [CNT_W-1:0]  bubble_q;
    logic [CNT_W-1:0]  bubble_d;
    logic [CNT_W-1:0]  stall_q;
    logic [CNT_W-1:0]  stall_d;

    assign drain_s       = head_valid_q & bus.out_ready;
    assign bus.out_valid = head_valid_q;
    assign bus.out_data  = head_data_q;
    assign bubble_cnt    = bubble_q;
    assign stall_cnt     = stall_q;

`ifdef PIPE_STAGE_SKID_EN
    logic              skid_valid_q;
    logic              skid_valid_d;
    logic [DATA_W-1:0] skid_data_q;
    logic [DATA_W-1:0] skid_data_d;
    logic              in_ready_q;
    logic              in_ready_d;

    // in_ready comes straight from a flop so out_ready never reaches it combinationally
    assign bus.in_ready = in_ready_q;
    assign accept_s     = bus.in_valid & in_ready_q & ~flush;
    assign in_ready_d   = ~skid_valid_d;

    // Next state of head and skid entries
    always_comb begin
        head_valid_d = head_valid_q;
        head_data_d  = head_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (flush) begin
            head_valid_d = 1'b0;
            skid_valid_d = 1'b0;
            if (CLEAR_DATA != 0) begin
                head_data_d = '0;
                skid_data_d = '0;
            end else begin
                head_data_d = head_data_q;
                skid_data_d = skid_data_q;
            end
        end else if (skid_valid_q) begin
            // Full: in_ready is low, so only a drain can move things along
            if (drain_s) begin
                head_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
            end else begin
                skid_valid_d = 1'b1;
            end
        end else if (accept_s) begin
            if (head_valid_q && !drain_s) begin
                skid_valid_d = 1'b1;
                skid_data_d  = bus.in_data;
            end else begin
                head_valid_d = 1'b1;
                head_data_d  = bus.in_data;
            end
        end else if (drain_s) begin
            head_valid_d = 1'b0;
        end else begin
            head_valid_d = head_valid_q;
        end
    end

    // Valid bits and registered in_ready
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            head_valid_q <= head_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    if (CLEAR_DATA != 0) begin : g_data_clr
        // Payload storage, cleared by reset
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                head_data_q <= '0;
                skid_data_q <= '0;
            end else begin
                head_data_q <= head_data_d;
                skid_data_q <= skid_data_d;
            end
        end
    end else begin : g_data_keep
        // Payload storage, left untouched by reset
        always_ff @(posedge clk) begin
            head_data_q <= head_data_d;
            skid_data_q <= skid_data_d;
        end
    end
`else
    logic in_ready_s;

    assign in_ready_s   = ~head_valid_q | bus.out_ready;
    assign bus.in_ready = in_ready_s;
    assign accept_s     = bus.in_valid & in_ready_s & ~flush;

    // Next state of the single head entry; accept-with-drain simply overwrites it
    always_comb begin
        head_valid_d = head_valid_q;
        head_data_d  = head_data_q;
        if (flush) begin
            head_valid_d = 1'b0;
            if (CLEAR_DATA != 0) begin
                head_data_d = '0;
            end else begin
                head_data_d = head_data_q;
            end
        end else if (accept_s) begin
            head_valid_d = 1'b1;
            head_data_d  = bus.in_data;
        end else if (drain_s) begin
            head_valid_d = 1'b0;
        end else begin
            head_valid_d = head_valid_q;
        end
    end

    // Head valid bit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_valid_q <= 1'b0;
        end else begin
            head_valid_q <= head_valid_d;
        end
    end

    if (CLEAR_DATA != 0) begin : g_data_clr
        // Head payload, cleared by reset
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                head_data_q <= '0;
            end else begin
                head_data_q <= head_data_d;
            end
        end
    end else begin : g_data_keep
        // Head payload, left untouched by reset
        always_ff @(posedge clk) begin
            head_data_q <= head_data_d;
        end
    end
`endif

    // Counter next state: clear wins over increment; flush has no effect here
    always_comb begin
        bubble_d = bubble_q;
        stall_d  = stall_q;
        if (cnt_clr) begin
            bubble_d = '0;
            stall_d  = '0;
        end else begin
            if (!head_valid_q) begin
                bubble_d = sat_inc(bubble_q);
            end else begin
                bubble_d = bubble_q;
            end
            if (head_valid_q && !bus.out_ready) begin
                stall_d = sat_inc(stall_q);
            end else begin
                stall_d = stall_q;
            end
        end
    end

    // Performance counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bubble_q <= '0;
            stall_q  <= '0;
        end else begin
            bubble_q <= bubble_d;
            stall_q  <= stall_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed table, corner sequences and a random run
// compared against a queue-based model of the stage.
module tb_pipe_stage_reg;

    localparam int DW   = 101;
    localparam int CW   = 16;
    localparam int MAXC = (1 << CW) - 1;
`ifdef PIPE_STAGE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic          flush;
    logic          cnt_clr;
    logic [CW-1:0] bubble_cnt;
    logic [CW-1:0] stall_cnt;
    logic          flush4;
    logic          cnt_clr4;
    logic [3:0]    bub4;
    logic [3:0]    stl4;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] mq[$];
    int            bub = 0;
    int            stl = 0;

    pipe_stage_reg_if #(.DATA_W(DW)) bus();
    pipe_stage_reg_if #(.DATA_W(8))  bus4();

    pipe_stage_reg #(.DATA_W(DW), .CNT_W(CW), .CLEAR_DATA(1)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus), .flush(flush),
        .cnt_clr(cnt_clr), .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt)
    );

    pipe_stage_reg #(.DATA_W(8), .CNT_W(4), .CLEAR_DATA(1)) dut4 (
        .clk(clk), .reset_n(reset_n), .bus(bus4), .flush(flush4),
        .cnt_clr(cnt_clr4), .bubble_cnt(bub4), .stall_cnt(stl4)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          iv;
        logic [DW-1:0] d;
        logic          ordy;
        logic          ov;
        logic [DW-1:0] od;
        logic          ir;
        logic [15:0]   bubv;
    } vec_t;

    vec_t tv[8];

    function automatic logic [DW-1:0] d8(input logic [7:0] v);
        return {{(DW-8){1'b0}}, v};
    endfunction

    function automatic logic [DW-1:0] rnd_data();
        logic [127:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom()};
        return t[DW-1:0];
    endfunction

    task automatic chk1(input string nm, input logic a, input logic e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %0b, expected %0b at %0t", nm, a, e, $time);
        end
    endtask

    task automatic chkd(input string nm, input logic [DW-1:0] a, input logic [DW-1:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, a, e, $time);
        end
    endtask

    task automatic chkc(input string nm, input logic [15:0] a, input logic [15:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, a, e, $time);
        end
    endtask

    task automatic drive(input logic iv, input logic [DW-1:0] d, input logic ordy,
                         input logic fl, input logic cc);
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = ordy;
        flush         = fl;
        cnt_clr       = cc;
        #1;
    endtask

    // Compare against the model with the currently driven inputs, then advance one clock.
    task automatic step();
        logic          ov;
        logic          ir;
        logic          drn;
        logic          acc;
        logic          ordy;
        logic          fl;
        logic          cc;
        logic [DW-1:0] din;
        ov   = (mq.size() > 0);
        ordy = bus.out_ready;
        fl   = flush;
        cc   = cnt_clr;
        din  = bus.in_data;
        ir   = SKID ? (mq.size() < 2) : (!ov || ordy);
        chk1("out_valid", bus.out_valid, ov);
        chk1("in_ready", bus.in_ready, ir);
        if (ov) chkd("out_data", bus.out_data, mq[0]);
        chkc("bubble_cnt", bubble_cnt, 16'(bub));
        chkc("stall_cnt", stall_cnt, 16'(stl));
        drn = ov && ordy;
        acc = bus.in_valid && ir && !fl;
        @(posedge clk);
        if (cc) begin
            bub = 0;
            stl = 0;
        end else begin
            if (!ov && bub < MAXC) bub++;
            if (ov && !ordy && stl < MAXC) stl++;
        end
        if (fl) begin
            mq.delete();
        end else begin
            if (drn) void'(mq.pop_front());
            if (acc) mq.push_back(din);
        end
        #1;
    endtask

    task automatic cycle(input logic iv, input logic [DW-1:0] d, input logic ordy,
                         input logic fl, input logic cc);
        drive(iv, d, ordy, fl, cc);
        step();
    endtask

    initial begin
        tv[0] = '{1'b1, d8(8'h01), 1'b1, 1'b0, d8(8'h00), 1'b1, 16'd0};
        tv[1] = '{1'b1, d8(8'h02), 1'b1, 1'b1, d8(8'h01), 1'b1, 16'd1};
        tv[2] = '{1'b1, d8(8'h03), 1'b1, 1'b1, d8(8'h02), 1'b1, 16'd1};
        tv[3] = '{1'b1, d8(8'h04), 1'b1, 1'b1, d8(8'h03), 1'b1, 16'd1};
        tv[4] = '{1'b1, d8(8'h05), 1'b1, 1'b1, d8(8'h04), 1'b1, 16'd1};
        tv[5] = '{1'b0, d8(8'h00), 1'b1, 1'b1, d8(8'h05), 1'b1, 16'd1};
        tv[6] = '{1'b0, d8(8'h00), 1'b1, 1'b0, d8(8'h00), 1'b1, 16'd1};
        tv[7] = '{1'b0, d8(8'h00), 1'b1, 1'b0, d8(8'h00), 1'b1, 16'd2};

        reset_n        = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.out_ready  = 1'b0;
        flush          = 1'b0;
        cnt_clr        = 1'b0;
        bus4.in_valid  = 1'b0;
        bus4.in_data   = 8'h00;
        bus4.out_ready = 1'b0;
        flush4         = 1'b0;
        cnt_clr4       = 1'b0;
        #2;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk1("rst_out_valid", bus.out_valid, 1'b0);
        chk1("rst_in_ready", bus.in_ready, 1'b1);
        chkd("rst_out_data", bus.out_data, d8(8'h00));
        chkc("rst_bubble", bubble_cnt, 16'd0);
        chkc("rst_stall", stall_cnt, 16'd0);
        reset_n = 1'b1;

        // Streaming table straight out of reset
        for (int i = 0; i < 8; i++) begin
            drive(tv[i].iv, tv[i].d, tv[i].ordy, 1'b0, 1'b0);
            chk1("tbl_out_valid", bus.out_valid, tv[i].ov);
            chk1("tbl_in_ready", bus.in_ready, tv[i].ir);
            if (tv[i].ov) chkd("tbl_out_data", bus.out_data, tv[i].od);
            chkc("tbl_bubble", bubble_cnt, tv[i].bubv);
            step();
        end

        // Back-pressure with head 0xA5
        cycle(1'b1, d8(8'hA5), 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, d8(8'h5A), 1'b0, 1'b0, 1'b0);
            chkd("bp_out_data", bus.out_data, d8(8'hA5));
            chk1("bp_in_ready", bus.in_ready, SKID && (i == 0));
            step();
        end
        drive(1'b0, d8(8'h00), 1'b0, 1'b0, 1'b0);
        chkc("bp_stall_cnt", stall_cnt, 16'd4);
        chkd("bp_hold_data", bus.out_data, d8(8'hA5));
        step();
        repeat (3) cycle(1'b0, d8(8'h00), 1'b1, 1'b0, 1'b0);

        // Flush with head 0x11 (and skid 0x22 when present), 0x33 offered alongside
        cycle(1'b1, d8(8'h11), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, d8(8'h22), 1'b0, 1'b0, 1'b0);
        drive(1'b1, d8(8'h33), 1'b1, 1'b1, 1'b0);
        chkd("fl_pre_data", bus.out_data, d8(8'h11));
        step();
        drive(1'b0, d8(8'h00), 1'b1, 1'b0, 1'b0);
        chk1("fl_out_valid", bus.out_valid, 1'b0);
        chkd("fl_out_data", bus.out_data, d8(8'h00));
        step();
        repeat (3) cycle(1'b0, d8(8'h00), 1'b1, 1'b0, 1'b0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, rnd_data(), $urandom_range(0, 2) != 0,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 31) == 0);
        end

        // Asynchronous reset between edges with the head valid
        cycle(1'b0, d8(8'h00), 1'b0, 1'b1, 1'b0);
        cycle(1'b1, d8(8'h77), 1'b0, 1'b0, 1'b0);
        drive(1'b0, d8(8'h00), 1'b0, 1'b0, 1'b0);
        chk1("ar_pre_valid", bus.out_valid, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk1("ar_out_valid", bus.out_valid, 1'b0);
        chk1("ar_in_ready", bus.in_ready, 1'b1);
        chkd("ar_out_data", bus.out_data, d8(8'h00));
        chkc("ar_bubble", bubble_cnt, 16'd0);
        chkc("ar_stall", stall_cnt, 16'd0);
        mq.delete();
        bub = 0;
        stl = 0;
        #1;
        reset_n = 1'b1;
        cycle(1'b1, d8(8'h42), 1'b1, 1'b0, 1'b0);
        drive(1'b0, d8(8'h00), 1'b1, 1'b0, 1'b0);
        chk1("pr_out_valid", bus.out_valid, 1'b1);
        chkd("pr_out_data", bus.out_data, d8(8'h42));
        step();
        repeat (2) cycle(1'b0, d8(8'h00), 1'b1, 1'b0, 1'b0);

        // Saturation of a 4-bit bubble counter on an idle stage
        cnt_clr4 = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr4 = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chkc("sat_bubble_10", {12'd0, bub4}, 16'd10);
        repeat (10) @(posedge clk);
        #1;
        chkc("sat_bubble_15", {12'd0, bub4}, 16'd15);
        chkc("sat_stall_0", {12'd0, stl4}, 16'd0);
        chk1("sat_out_valid", bus4.out_valid, 1'b0);
        cnt_clr4 = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr4 = 1'b0;
        chkc("sat_clr", {12'd0, bub4}, 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL provide parameter DATA_W, default 101, meaning width of the packed stage payload (ALUResult 32 + WriteData 32 + Rd 5 + PCPlus4 32).
REQ-002 SHALL provide parameter CNT_W, default 16, meaning width of each performance counter.
REQ-003 SHALL provide parameter CLEAR_DATA, default 1, meaning: when 1, flush and reset zero the payload storage; when 0, only valid bits clear.
REQ-004 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port in_valid  input  1  upstream payload valid.
REQ-007 SHALL have port in_ready  output  1  stage can accept the payload this cycle.
REQ-008 SHALL have port in_data  input  DATA_W  upstream payload.
REQ-009 SHALL have port flush  input  1  synchronous kill of all held entries.
REQ-010 SHALL have port out_valid  output  1  downstream payload valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts this cycle.
REQ-012 SHALL have port out_data  output  DATA_W  downstream payload, driven directly from the head register.
REQ-013 SHALL have port cnt_clr  input  1  synchronous clear of both counters.
REQ-014 SHALL have port bubble_cnt  output  CNT_W  cycles with out_valid=0.
REQ-015 SHALL have port stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0.

Function
REQ-016 Transfers SHALL occur only on in_valid&in_ready (accept) and on out_valid&out_ready (drain).
REQ-017 Latency from accept to out_valid SHALL be exactly 1 cycle when the stage is empty.
REQ-018 Without skid: one head entry; in_ready SHALL equal !out_valid | out_ready (combinational).
REQ-019 Without skid: simultaneous drain and accept SHALL replace the head with in_data, out_valid staying 1, no bubble.
REQ-020 Payload order SHALL be preserved; no payload SHALL be duplicated or dropped except by flush.
REQ-021 flush=1 SHALL clear every valid bit at the next edge and discard any in_data offered that cycle, regardless of in_valid, out_ready.
REQ-022 in_ready SHALL remain asserted per its normal rule during flush; the accept is ignored, not back-pressured.
REQ-023 With CLEAR_DATA=1, flush SHALL also zero all payload registers.
REQ-024 bubble_cnt SHALL increment by 1 on each edge where out_valid was 0; stall_cnt likewise where out_valid=1 and out_ready=0.
REQ-025 Counters SHALL saturate at all-ones and not wrap.
REQ-026 cnt_clr SHALL zero both counters at the next edge, taking priority over increment.
REQ-027 Counters SHALL be unaffected by flush.

Reset
REQ-028 reset_n=0 SHALL immediately, without clk, force out_valid=0, bubble_cnt=0, stall_cnt=0, skid valid=0.
REQ-029 Reset SHALL force out_data=0 when CLEAR_DATA=1; otherwise out_data is don't-care.
REQ-030 in_ready SHALL be 1 while and after reset (empty stage).
REQ-031 Reset mid-transfer SHALL discard all held entries; first post-reset accept SHALL behave as on an empty stage.

Configuration
REQ-032 Macro PIPE_STAGE_SKID_EN SHALL, when defined, add one skid entry behind the head (capacity 2).
REQ-033 With PIPE_STAGE_SKID_EN: in_ready SHALL be registered, equal to !skid_valid, with no combinational path from out_ready.
REQ-034 With PIPE_STAGE_SKID_EN: accept while head valid and out_ready=0 SHALL load the skid; drain with skid valid SHALL move skid to head on the same edge.
REQ-035 Without PIPE_STAGE_SKID_EN: behaviour SHALL be exactly REQ-018/019, capacity 1.

Verification
REQ-036 Stream: in_valid=1 data 0x01..0x05, out_ready=1 -> out_data 0x01..0x05 one cycle later each, bubble_cnt=1 (first cycle) only.
REQ-037 Back-pressure: hold out_ready=0 4 cycles with head 0xA5 -> out_data stays 0xA5, stall_cnt=4; no skid: in_ready=0; skid: one more accept, then in_ready=0.
REQ-038 Flush: head 0x11 valid, skid 0x22 valid, flush=1 with in_data 0x33 -> next cycle out_valid=0, 0x33 never appears, out_data=0 (CLEAR_DATA=1).
REQ-039 Async reset: reset_n low mid-cycle between edges with head valid -> out_valid=0 and counters 0 before next clk edge.
REQ-040 Saturation: CNT_W=4, idle 20 cycles -> bubble_cnt=15; cnt_clr=1 together with a bubble -> bubble_cnt=0.
